// File: rtl/writeback_stage.sv
// Writeback stage of the LEGv8 core: retires ALU results and extended load data to the register file.
// Optional feature: define WB_RETIRE_COUNT_EN to add the retire_count output.
module writeback_stage (
`ifdef WB_RETIRE_COUNT_EN
  output logic [31:0] retire_count,
`endif
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mw_valid,
  output logic        mw_ready,
  input  logic [4:0]  mw_rd,
  input  logic [63:0] mw_alu_result,
  input  logic        mw_regwrite,
  input  logic        mw_memtoreg,
  input  logic [1:0]  mw_load_size,
  input  logic        mw_load_signed,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rsp_data,
  input  logic        wb_flush,
  output logic [4:0]  writeAddress,
  output logic [63:0] writeData,
  output logic        regwrite
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StDrain} state_e;

  state_e      stateQ, stateD;
  logic [4:0]  ldRdQ, ldRdD;
  logic        ldRegwriteQ, ldRegwriteD;
  logic [1:0]  ldSizeQ, ldSizeD;
  logic        ldSignedQ, ldSignedD;

  logic        wrEnD;
  logic        wrUpdate;
  logic [4:0]  wrAddrD;
  logic [63:0] wrDataD;
  logic        retireD;
  logic        transfer;

  assign mw_ready = rst_n && (stateQ == StIdle);
  assign transfer = mw_valid && mw_ready;

  function automatic logic [63:0] extendLoad(input logic [63:0] data, input logic [1:0] size,
                                             input logic sgn);
    logic [63:0] res;
    unique case (size)
      2'b00:   res = {{56{sgn & data[7]}},  data[7:0]};
      2'b01:   res = {{48{sgn & data[15]}}, data[15:0]};
      2'b10:   res = {{32{sgn & data[31]}}, data[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  always_comb begin
    stateD      = stateQ;
    ldRdD       = ldRdQ;
    ldRegwriteD = ldRegwriteQ;
    ldSizeD     = ldSizeQ;
    ldSignedD   = ldSignedQ;
    wrEnD       = 1'b0;
    wrUpdate    = 1'b0;
    wrAddrD     = writeAddress;
    wrDataD     = writeData;
    retireD     = 1'b0;
    unique case (stateQ)
      StIdle: begin
        // A flushed transfer is consumed without touching any state.
        if (transfer && !wb_flush) begin
          if (mw_memtoreg) begin
            ldRdD       = mw_rd;
            ldRegwriteD = mw_regwrite;
            ldSizeD     = mw_load_size;
            ldSignedD   = mw_load_signed;
            stateD      = StWaitMem;
          end else begin
            wrEnD   = mw_regwrite && (mw_rd != 5'd31);
            wrAddrD = mw_rd;
            wrDataD = mw_alu_result;
            retireD = 1'b1;
          end
        end
      end
      StWaitMem: begin
        if (dmem_rsp_valid) begin
          stateD = StIdle;
          if (!wb_flush) begin
            wrEnD   = ldRegwriteQ && (ldRdQ != 5'd31);
            wrAddrD = ldRdQ;
            wrDataD = extendLoad(dmem_rsp_data, ldSizeQ, ldSignedQ);
            retireD = 1'b1;
          end
        end else if (wb_flush) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        if (dmem_rsp_valid) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
    wrUpdate = wrEnD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ       <= StIdle;
      ldRdQ        <= 5'd0;
      ldRegwriteQ  <= 1'b0;
      ldSizeQ      <= 2'd0;
      ldSignedQ    <= 1'b0;
      regwrite     <= 1'b0;
      writeAddress <= 5'd0;
      writeData    <= 64'd0;
    end else begin
      stateQ      <= stateD;
      ldRdQ       <= ldRdD;
      ldRegwriteQ <= ldRegwriteD;
      ldSizeQ     <= ldSizeD;
      ldSignedQ   <= ldSignedD;
      regwrite    <= wrEnD;
      // Address and data hold whenever no write is issued.
      if (wrUpdate) begin
        writeAddress <= wrAddrD;
        writeData    <= wrDataD;
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= 32'd0;
    end else if (retireD) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`else
  logic unusedRetire;
  assign unusedRetire = retireD;
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the LEGv8 core: accepts retiring instructions from the memory stage over a valid/ready handshake, waits for data-memory load responses, and size/sign-extends load data. It drives the register file's write port (writeAddress, writeData, regwrite) from registered outputs. Writes to X31 (XZR) are suppressed so the zero register stays zero.

## Interface
- No parameters; data width fixed at 64, register index width fixed at 5.
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mw_valid  input  1  memory stage presents a retiring instruction.
- mw_ready  output  1  stage can accept; `mw_ready = rst_n && (state == IDLE)` (combinational).
- mw_rd  input  5  destination register index.
- mw_alu_result  input  64  ALU result, used when mw_memtoreg = 0.
- mw_regwrite  input  1  instruction writes a register.
- mw_memtoreg  input  1  result comes from a data-memory load.
- mw_load_size  input  2  load width: 00 byte, 01 half, 10 word, 11 doubleword.
- mw_load_signed  input  1  sign-extend load data; 0 means zero-extend.
- dmem_rsp_valid  input  1  load response valid, single-cycle pulse.
- dmem_rsp_data  input  64  load data; the value is right-aligned in bits [size-1:0].
- wb_flush  input  1  discard the current or pending instruction.
- writeAddress  output  5  register-file write index (registered).
- writeData  output  64  register-file write data (registered).
- regwrite  output  1  register-file write enable, one-cycle pulse (registered).

## Operation
- FSM states:
  - IDLE: accepts new instructions.
  - WAIT_MEM: a load is pending.
  - DRAIN: a flushed load is waiting for its response.
- Transfer happens when mw_valid && mw_ready.
- IDLE, transfer, mw_memtoreg = 0:
  - Next cycle: writeAddress = mw_rd, writeData = mw_alu_result.
  - regwrite = mw_regwrite && (mw_rd != 31).
  - Stay in IDLE.
- IDLE, transfer, mw_memtoreg = 1:
  - Latch rd, regwrite, size and signed flag.
  - Go to WAIT_MEM. regwrite = 0 next cycle.
- WAIT_MEM, dmem_rsp_valid:
  - Next cycle: writeData = extended response, writeAddress = latched rd.
  - regwrite = latched regwrite && (rd != 31).
  - Go to IDLE.
- Extension of the response:
  - Size field selects bits [7:0], [15:0], [31:0] or [63:0].
  - Upper bits are filled with the selected MSB when signed, else with 0.
  - Signed is ignored for doubleword.
- When regwrite is 0, writeAddress and writeData hold their previous values.
- Flush cases:
  - wb_flush in IDLE: an instruction transferred that cycle is consumed but not written; regwrite = 0 next cycle.
  - wb_flush in WAIT_MEM without dmem_rsp_valid: go to DRAIN. DRAIN waits for dmem_rsp_valid, discards it, then returns to IDLE.
  - wb_flush and dmem_rsp_valid in the same cycle (WAIT_MEM or DRAIN): response discarded, go to IDLE, no write.
  - wb_flush while already in DRAIN: no additional effect.
- dmem_rsp_valid in IDLE is ignored; no write occurs.

## Timing
- Reset values: state = IDLE, regwrite = 0, writeAddress = 0, writeData = 0, latched fields = 0.
- mw_ready is 0 while rst_n is low.
- Reset asserted in WAIT_MEM or DRAIN abandons the load. A response arriving after reset release is ignored, as it falls into IDLE.
- ALU op: transfer at cycle N, regwrite high during cycle N+1. Throughput is one instruction per cycle.
- Load: dmem_rsp_valid at cycle M, regwrite high during cycle M+1. mw_ready is low from the cycle after transfer through cycle M.
- Earliest next transfer after a load is cycle M+1.
- The register file captures writeData while regwrite is high. No combinational path runs from any input to writeAddress, writeData or regwrite.

## Configuration
- WB_RETIRE_COUNT_EN defined:
  - Adds output retire_count [31:0], reset to 0.
  - Increments in the cycle regwrite or a non-writing retirement is registered. Flushed instructions are not counted.
  - Wraps from 0xFFFFFFFF to 0.
- WB_RETIRE_COUNT_EN undefined: the port and counter logic are absent, and behaviour is otherwise identical.

## Test plan
- ALU op back-to-back:
  - Stimulus: transfer rd=3, result 0x1234 at cycle 5; transfer rd=4, result 0x55 at cycle 6.
  - Response: regwrite high at cycles 6 and 7 with (3, 0x1234) then (4, 0x55).
- XZR suppression:
  - Stimulus: transfer rd=31, regwrite=1, result 0xDEAD.
  - Response: regwrite stays 0.
- Signed byte load:
  - Stimulus: load rd=7, size 00, signed=1; response 0x80 arrives 3 cycles later.
  - Response: writeData = 0xFFFFFFFFFFFFFF80 one cycle after the response; mw_ready low during the wait.
- Unsigned word load:
  - Stimulus: response 0xFFFFFFFF_80000001 with size 10, signed=0.
  - Response: writeData = 0x0000000080000001.
- Flush in WAIT_MEM:
  - Stimulus: flush 1 cycle after a load transfer; response arrives 2 cycles later.
  - Response: no regwrite; mw_ready returns high the cycle after the response.
- Reset mid-load:
  - Stimulus: assert rst_n = 0 in WAIT_MEM, release, then pulse dmem_rsp_valid.
  - Response: all outputs 0; no write; retire_count = 0 with WB_RETIRE_COUNT_EN defined.
